// File: rtl/jogador_automatico_if.sv
// Signal bundle between the automatic player and its surroundings: the game's
// LED/result lines, the player's button drive, and the player's control/status.
interface jogador_automatico_if;
  logic       habilitar;
  logic [3:0] leds;
  logic       ganhou;
  logic       perdeu;
  logic [1:0] modo;
  logic [3:0] erro_rodada;
  logic [3:0] erro_jogada;
  logic [3:0] botoes;
  logic [3:0] rodada;
  logic       ocupado;
  logic       fim;
  logic       estouro;

  // Board / bench side: drives the game outputs and the player controls.
  modport master (
    output habilitar, leds, ganhou, perdeu, modo, erro_rodada, erro_jogada,
    input  botoes, rodada, ocupado, fim, estouro
  );

  // Player side.
  modport slave (
    input  habilitar, leds, ganhou, perdeu, modo, erro_rodada, erro_jogada,
    output botoes, rodada, ocupado, fim, estouro
  );
endinterface

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: listens to the LED display, stores
// each one-hot value shown, then replays the stored sequence on the buttons
// with fixed hold/gap timing. Can inject a wrong press or a missing press at
// a chosen round/play to exercise the game's error paths.
module jogador_automatico #(
  parameter int MAX_JOGADAS     = 16,
  parameter int HOLD_CYCLES     = 10,
  parameter int GAP_CYCLES      = 10,
  parameter int SILENCIO_CYCLES = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  jogador_automatico_if.slave  bus
);

  localparam int IW   = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
  localparam int NW   = $clog2(MAX_JOGADAS + 1);
  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int SW   = $clog2(SILENCIO_CYCLES + 1);

  typedef enum logic [2:0] {
    OCIOSO       = 3'd0,
    OUVINDO      = 3'd1,
    CAPTURA      = 3'd2,
    REPETE_PRESS = 3'd3,
    REPETE_SOLTA = 3'd4,
    AGUARDA      = 3'd5,
    FIM          = 3'd6
  } estado_t;

  // True when exactly one bit of a 4-bit value is set.
  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Rotated value is always a different button than the stored one.
  function automatic logic [3:0] rotate_wrong(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  estado_t          state_q, state_d;
  logic [NW-1:0]    n_q, n_d;
  logic [IW-1:0]    i_q, i_d;
  logic [SW-1:0]    sil_q, sil_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       rodada_q, rodada_d;
  logic [3:0]       botoes_q, botoes_d;
  logic             estouro_q, estouro_d;
  logic             ocupado_q, ocupado_d;
  logic             fim_q, fim_d;
  logic [3:0]       buf_q [MAX_JOGADAS];

  logic             wr_en_s;
  logic             go_press_s;
  logic [IW-1:0]    start_idx_s;
  logic [3:0]       start_val_s;
  logic             inj_hit_s;
  logic             inj_wrong_s;
  logic             inj_timeout_s;
  logic [SW-1:0]    sil_inc_s;

  // Which play would start next, its stored value and whether it is the injection target.
  always_comb begin
    if (state_q == REPETE_SOLTA) begin
      start_idx_s = i_q + {{(IW-1){1'b0}}, 1'b1};
    end else begin
      start_idx_s = {IW{1'b0}};
    end
    start_val_s   = buf_q[start_idx_s];
    inj_hit_s     = (rodada_q == bus.erro_rodada) &&
                    ((32'(start_idx_s) + 32'd1) == 32'(bus.erro_jogada));
    inj_wrong_s   = inj_hit_s && (bus.modo == 2'b01);
    inj_timeout_s = inj_hit_s && (bus.modo == 2'b10);
    if (sil_q == SW'(SILENCIO_CYCLES)) begin
      sil_inc_s = sil_q;
    end else begin
      sil_inc_s = sil_q + {{(SW-1){1'b0}}, 1'b1};
    end
  end

  // Next-state and next-output computation for the player.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    i_d        = i_q;
    sil_d      = sil_q;
    cnt_d      = cnt_q;
    rodada_d   = rodada_q;
    botoes_d   = botoes_q;
    estouro_d  = estouro_q;
    wr_en_s    = 1'b0;
    go_press_s = 1'b0;

    if (!bus.habilitar) begin
      state_d   = OCIOSO;
      n_d       = {NW{1'b0}};
      i_d       = {IW{1'b0}};
      sil_d     = {SW{1'b0}};
      cnt_d     = {CW{1'b0}};
      rodada_d  = 4'd0;
      botoes_d  = 4'd0;
      estouro_d = 1'b0;
    end else if (state_q == OCIOSO) begin
      state_d   = OUVINDO;
      n_d       = {NW{1'b0}};
      i_d       = {IW{1'b0}};
      sil_d     = {SW{1'b0}};
      cnt_d     = {CW{1'b0}};
      rodada_d  = 4'd1;
      botoes_d  = 4'd0;
    end else if (bus.ganhou || bus.perdeu) begin
      state_d  = FIM;
      botoes_d = 4'd0;
    end else begin
      case (state_q)
        OUVINDO: begin
          botoes_d = 4'd0;
          if (is_one_hot(bus.leds)) begin
            if (n_q == NW'(MAX_JOGADAS)) begin
              estouro_d = 1'b1;
            end else begin
              wr_en_s = 1'b1;
              n_d     = n_q + {{(NW-1){1'b0}}, 1'b1};
            end
            sil_d   = {SW{1'b0}};
            state_d = CAPTURA;
          end else if (bus.leds == 4'd0) begin
            sil_d = sil_inc_s;
            if ((n_q != {NW{1'b0}}) && (sil_inc_s == SW'(SILENCIO_CYCLES))) begin
              i_d        = {IW{1'b0}};
              go_press_s = 1'b1;
            end else begin
              go_press_s = 1'b0;
            end
          end else begin
            sil_d = sil_q;
          end
        end
        CAPTURA: begin
          botoes_d = 4'd0;
          // The zero that ends the pulse is the first silent sample.
          if (bus.leds == 4'd0) begin
            sil_d   = {{(SW-1){1'b0}}, 1'b1};
            state_d = OUVINDO;
          end else begin
            state_d = CAPTURA;
          end
        end
        REPETE_PRESS: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            cnt_d    = {CW{1'b0}};
            botoes_d = 4'd0;
            state_d  = REPETE_SOLTA;
          end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        REPETE_SOLTA: begin
          botoes_d = 4'd0;
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            cnt_d = {CW{1'b0}};
            if ((NW'(i_q) + {{(NW-1){1'b0}}, 1'b1}) < n_q) begin
              i_d        = start_idx_s;
              go_press_s = 1'b1;
            end else begin
              n_d     = {NW{1'b0}};
              i_d     = {IW{1'b0}};
              sil_d   = {SW{1'b0}};
              state_d = OUVINDO;
              if (rodada_q == 4'd15) begin
                rodada_d = rodada_q;
              end else begin
                rodada_d = rodada_q + 4'd1;
              end
            end
          end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        AGUARDA: begin
          botoes_d = 4'd0;
        end
        FIM: begin
          botoes_d = 4'd0;
        end
        default: begin
          state_d  = OCIOSO;
          botoes_d = 4'd0;
        end
      endcase

      // Starting a play: either press (possibly the wrong button) or hang silently.
      if (go_press_s) begin
        cnt_d = {CW{1'b0}};
        if (inj_timeout_s) begin
          state_d  = AGUARDA;
          botoes_d = 4'd0;
        end else if (inj_wrong_s) begin
          state_d  = REPETE_PRESS;
          botoes_d = rotate_wrong(start_val_s);
        end else begin
          state_d  = REPETE_PRESS;
          botoes_d = start_val_s;
        end
      end else begin
        cnt_d = cnt_d;
      end
    end

    ocupado_d = (state_d != OCIOSO) && (state_d != FIM);
    fim_d     = (state_d == FIM);
  end

  // Player state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= OCIOSO;
      n_q       <= {NW{1'b0}};
      i_q       <= {IW{1'b0}};
      sil_q     <= {SW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      rodada_q  <= 4'd0;
      botoes_q  <= 4'd0;
      estouro_q <= 1'b0;
      ocupado_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      i_q       <= i_d;
      sil_q     <= sil_d;
      cnt_q     <= cnt_d;
      rodada_q  <= rodada_d;
      botoes_q  <= botoes_d;
      estouro_q <= estouro_d;
      ocupado_q <= ocupado_d;
      fim_q     <= fim_d;
    end
  end

  // Capture buffer; contents after reset do not matter.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      buf_q[n_q[IW-1:0]] <= bus.leds;
    end
  end

  assign bus.botoes  = botoes_q;
  assign bus.rodada  = rodada_q;
  assign bus.ocupado = ocupado_q;
  assign bus.fim     = fim_q;
  assign bus.estouro = estouro_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Self-checking bench for jogador_automatico: a timeline-based reference model
// predicts every output each cycle; directed scenarios add literal expectations.
module tb_jogador_automatico;

  localparam int MAXJ = 4;
  localparam int HOLD = 10;
  localparam int GAP  = 10;
  localparam int SIL  = 20;
  localparam int PLAY = HOLD + GAP;

  logic clock = 1'b0;
  logic reset;

  jogador_automatico_if jif ();

  jogador_automatico #(
    .MAX_JOGADAS(MAXJ), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .SILENCIO_CYCLES(SIL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (jif.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {P_IDLE, P_LISTEN, P_REPLAY, P_HANG, P_END} phase_t;
  phase_t     m_phase   = P_IDLE;
  logic [3:0] m_seq[$];
  int         m_sil     = 0;
  bit         m_pulse   = 1'b0;
  int         m_t       = 0;
  logic [3:0] m_cur     = 4'd0;
  int         m_rodada  = 0;
  bit         m_estouro = 1'b0;
  int         e_botoes  = 0;
  int         e_ocupado = 0;
  int         e_fim     = 0;

  function automatic bit one_hot(input logic [3:0] v);
    int c;
    c = 0;
    for (int b = 0; b < 4; b++) if (v[b]) c++;
    return c == 1;
  endfunction

  task automatic start_play(input int p);
    logic [3:0] v;
    bit hit;
    v   = m_seq[p];
    hit = (m_rodada == int'(jif.erro_rodada)) && (p + 1 == int'(jif.erro_jogada));
    if (hit && jif.modo == 2'b10) m_phase = P_HANG;
    else if (hit && jif.modo == 2'b01) m_cur = 4'(((int'(v) * 2) + (int'(v) / 8)) % 16);
    else m_cur = v;
  endtask

  task automatic model_outputs();
    e_botoes  = (m_phase == P_REPLAY && (m_t % PLAY) < HOLD) ? int'(m_cur) : 0;
    e_ocupado = (m_phase == P_LISTEN || m_phase == P_REPLAY || m_phase == P_HANG) ? 1 : 0;
    e_fim     = (m_phase == P_END) ? 1 : 0;
  endtask

  task automatic model_clear();
    m_phase = P_IDLE; m_seq.delete(); m_sil = 0; m_pulse = 1'b0; m_t = 0;
    m_rodada = 0; m_estouro = 1'b0;
    model_outputs();
  endtask

  task automatic model_step();
    if (!jif.habilitar) model_clear();
    else if (m_phase == P_IDLE) begin
      m_phase = P_LISTEN; m_rodada = 1; m_seq.delete(); m_sil = 0; m_pulse = 1'b0;
    end else if (jif.ganhou || jif.perdeu) m_phase = P_END;
    else if (m_phase == P_LISTEN) begin
      if (m_pulse) begin
        if (jif.leds == 4'd0) begin m_pulse = 1'b0; m_sil = 1; end
      end else if (one_hot(jif.leds)) begin
        if (m_seq.size() < MAXJ) m_seq.push_back(jif.leds);
        else m_estouro = 1'b1;
        m_pulse = 1'b1; m_sil = 0;
      end else if (jif.leds == 4'd0) begin
        m_sil++;
        if (m_seq.size() > 0 && m_sil >= SIL) begin
          m_phase = P_REPLAY; m_t = 0; start_play(0);
        end
      end
    end else if (m_phase == P_REPLAY) begin
      m_t++;
      if (m_t == m_seq.size() * PLAY) begin
        m_seq.delete(); m_sil = 0; m_phase = P_LISTEN;
        if (m_rodada < 15) m_rodada++;
      end else if (m_t % PLAY == 0) start_play(m_t / PLAY);
    end
    model_outputs();
  endtask

  // Model advances on every rising edge and on asynchronous reset.
  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) model_clear();
    else begin cyc++; model_step(); end
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clock);
    chk("botoes",  int'(jif.botoes),  e_botoes);
    chk("rodada",  int'(jif.rodada),  m_rodada);
    chk("ocupado", int'(jif.ocupado), e_ocupado);
    chk("fim",     int'(jif.fim),     e_fim);
    chk("estouro", int'(jif.estouro), int'(m_estouro));
  end

  // Press log: value, high length and start cycle of every button pulse.
  logic [3:0] lg_val[$];
  int         lg_len[$];
  int         lg_start[$];
  logic [3:0] mon_prev = 4'd0;
  int         mon_len = 0;
  int         mon_start = 0;
  initial forever begin
    @(negedge clock);
    if (jif.botoes != mon_prev) begin
      if (mon_prev != 4'd0) begin
        lg_val.push_back(mon_prev); lg_len.push_back(mon_len); lg_start.push_back(mon_start);
      end
      if (jif.botoes != 4'd0) begin mon_start = cyc; mon_len = 0; end
    end
    if (jif.botoes != 4'd0) mon_len++;
    mon_prev = jif.botoes;
  end

  task automatic clear_log();
    lg_val.delete(); lg_len.delete(); lg_start.delete();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input int k);
    repeat (k) begin @(posedge clock); #2; end
  endtask

  task automatic pulse(input logic [3:0] v, input int len, input int gap);
    jif.leds = v; step(len);
    jif.leds = 4'd0; step(gap);
  endtask

  task automatic stop_game();
    jif.ganhou = 1'b0; jif.perdeu = 1'b0; jif.leds = 4'd0;
    jif.habilitar = 1'b0; step(2);
  endtask

  logic [3:0] noise_tab [7];
  int t_zero;
  int k, act;

  initial begin
    reset = 1'b0;
    jif.habilitar = 1'b0; jif.leds = 4'd0; jif.ganhou = 1'b0; jif.perdeu = 1'b0;
    jif.modo = 2'b00; jif.erro_rodada = 4'd0; jif.erro_jogada = 4'd0;
    noise_tab[0] = 4'b0011; noise_tab[1] = 4'b0101; noise_tab[2] = 4'b0110;
    noise_tab[3] = 4'b1001; noise_tab[4] = 4'b1010; noise_tab[5] = 4'b1100;
    noise_tab[6] = 4'b1111;
    step(3);
    chk("rst_botoes", int'(jif.botoes), 0);
    chk("rst_rodada", int'(jif.rodada), 0);
    chk("rst_ocupado", int'(jif.ocupado), 0);
    chk("rst_fim", int'(jif.fim), 0);
    reset = 1'b1;
    step(2);

    // Normal play, two rounds, then win.
    jif.habilitar = 1'b1; step(2);
    chk("a_rodada1", int'(jif.rodada), 1);
    chk("a_ocupado", int'(jif.ocupado), 1);
    clear_log();
    pulse(4'b0001, 3, 0); t_zero = cyc;
    step(PLAY + 30);
    chk("a_r1_npress", lg_val.size(), 1);
    chk("a_r1_val", int'(lg_val[0]), 1);
    chk("a_r1_len", lg_len[0], 10);
    chk("a_r1_delay", lg_start[0] - t_zero, 20);
    chk("a_rodada2", int'(jif.rodada), 2);
    clear_log();
    pulse(4'b0001, 4, 5); pulse(4'b0100, 6, 0);
    step(2 * PLAY + 30);
    chk("a_r2_npress", lg_val.size(), 2);
    chk("a_r2_val0", int'(lg_val[0]), 1);
    chk("a_r2_val1", int'(lg_val[1]), 4);
    chk("a_r2_len1", lg_len[1], 10);
    chk("a_r2_period", lg_start[1] - lg_start[0], 20);
    jif.ganhou = 1'b1; step(1); jif.ganhou = 1'b0;
    chk("a_fim", int'(jif.fim), 1);
    chk("a_fim_ocupado", int'(jif.ocupado), 0);
    step(3);
    chk("a_fim_hold", int'(jif.fim), 1);
    stop_game();
    chk("a_idle_rodada", int'(jif.rodada), 0);

    // Wrong press at round 2 play 2, then lose mid-press.
    jif.modo = 2'b01; jif.erro_rodada = 4'd2; jif.erro_jogada = 4'd2;
    jif.habilitar = 1'b1; step(1);
    pulse(4'b0001, 3, 0); step(PLAY + 30);
    clear_log();
    pulse(4'b0001, 3, 4); pulse(4'b0100, 3, 0);
    step(43);
    chk("b_wrong_now", int'(jif.botoes), 8);
    chk("b_first", int'(lg_val[0]), 1);
    jif.perdeu = 1'b1; step(1); jif.perdeu = 1'b0;
    chk("b_fim", int'(jif.fim), 1);
    chk("b_botoes0", int'(jif.botoes), 0);
    stop_game();

    // Missing press at round 2 play 1.
    jif.modo = 2'b10; jif.erro_rodada = 4'd2; jif.erro_jogada = 4'd1;
    jif.habilitar = 1'b1; step(1);
    pulse(4'b0010, 2, 0); step(PLAY + 30);
    clear_log();
    pulse(4'b1000, 2, 0); step(3000);
    chk("c_no_press", lg_val.size(), 0);
    chk("c_ocupado", int'(jif.ocupado), 1);
    chk("c_rodada", int'(jif.rodada), 2);
    jif.perdeu = 1'b1; step(1); jif.perdeu = 1'b0;
    chk("c_fim", int'(jif.fim), 1);
    stop_game();

    // Filtering of non-one-hot values and long pulses.
    jif.modo = 2'b00; jif.habilitar = 1'b1; step(1);
    clear_log();
    jif.leds = 4'b0011; step(5);
    jif.leds = 4'b0010; step(30);
    jif.leds = 4'd0; t_zero = cyc; step(60);
    chk("d_npress", lg_val.size(), 1);
    chk("d_val", int'(lg_val[0]), 2);
    chk("d_delay", lg_start[0] - t_zero, 20);

    // Overflow: five captures into a four-entry buffer.
    clear_log();
    pulse(4'b0001, 2, 3); pulse(4'b0010, 2, 3); pulse(4'b0100, 2, 3);
    pulse(4'b1000, 2, 3); pulse(4'b0001, 2, 0);
    chk("e_estouro", int'(jif.estouro), 1);
    step(4 * PLAY + 30);
    chk("e_npress", lg_val.size(), 4);
    chk("e_last", int'(lg_val[3]), 8);
    chk("e_estouro_sticky", int'(jif.estouro), 1);

    // Asynchronous reset in the middle of a press.
    pulse(4'b0100, 2, 0); step(21);
    chk("f_pressing", int'(jif.botoes), 4);
    #1 reset = 1'b0;
    #1;
    chk("f_rst_botoes", int'(jif.botoes), 0);
    chk("f_rst_rodada", int'(jif.rodada), 0);
    chk("f_rst_estouro", int'(jif.estouro), 0);
    reset = 1'b1;
    step(1);
    pulse(4'b0001, 2, 0); step(22);
    chk("f_press2", int'(jif.botoes), 1);
    jif.habilitar = 1'b0; step(1);
    chk("f_off_ocupado", int'(jif.ocupado), 0);
    chk("f_off_botoes", int'(jif.botoes), 0);
    step(2);

    // Randomized games checked by the model every cycle.
    for (int g = 0; g < 8; g++) begin
      jif.modo = 2'($urandom_range(0, 3));
      jif.erro_rodada = 4'($urandom_range(1, 3));
      jif.erro_jogada = 4'($urandom_range(1, 3));
      jif.habilitar = 1'b1; step(1);
      for (int r = 0; r < 4; r++) begin
        k = $urandom_range(1, 5);
        for (int p = 0; p < k; p++) begin
          if ($urandom_range(0, 3) == 0) begin
            jif.leds = noise_tab[$urandom_range(0, 6)];
            step($urandom_range(1, 3));
          end
          pulse(4'(1 << $urandom_range(0, 3)), $urandom_range(1, 8),
                (p == k - 1) ? 0 : $urandom_range(1, 10));
        end
        if ($urandom_range(0, 7) == 0) begin
          step($urandom_range(0, 60));
          jif.perdeu = 1'b1; step(1); jif.perdeu = 1'b0;
        end
        step(((k > MAXJ) ? MAXJ : k) * PLAY + 30);
      end
      act = $urandom_range(0, 2);
      if (act == 0) begin
        jif.ganhou = 1'b1; step(1); jif.ganhou = 1'b0; step(3);
      end else if (act == 1) begin
        jif.perdeu = 1'b1; jif.habilitar = 1'b0; step(1);
        chk("g_prio_fim", int'(jif.fim), 0);
      end
      stop_game();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
